// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding
// and the pattern-length clamp.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // A requested length of 0, or one wider than the pattern register, means "use the full width".
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned pat_w);
        return (len == 0 || len > pat_w) ? pat_w : len;
    endfunction

endpackage

// File: rtl/seq_piso_shifter.sv
// Loadable parallel-in/serial-out register. bit_out is registered and reads 0
// in any cycle that was not commanded to carry a pattern bit.
module seq_piso_shifter #(
    parameter int PAT_W = 3,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             restart,
    input  logic             advance,
    input  logic [PAT_W-1:0] data,
    input  logic [LEN_W-1:0] len,
    output logic             bit_out,
    output logic             last_bit
);

    logic [PAT_W-1:0] sreg;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] sel;
    logic [PAT_W-1:0] src;
    logic [PAT_W-1:0] shifted;

    // idx always names the bit currently on the line; sel picks the bit for the next cycle.
    always_comb begin
        sel = idx - LEN_W'(1);
        src = sreg;
        if (load) begin
            sel = len - LEN_W'(1);
            src = data;
        end else if (restart) begin
            sel = len_q - LEN_W'(1);
        end
        shifted = src >> sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg    <= '0;
            len_q   <= '0;
            idx     <= '0;
            bit_out <= 1'b0;
        end else begin
            bit_out <= 1'b0;
            if (load) begin
                sreg    <= data;
                len_q   <= len;
                idx     <= len - LEN_W'(1);
                bit_out <= shifted[0];
            end else if (restart) begin
                idx     <= len_q - LEN_W'(1);
                bit_out <= shifted[0];
            end else if (advance && idx != '0) begin
                idx     <= idx - LEN_W'(1);
                bit_out <= shifted[0];
            end
        end
    end

    assign last_bit = (idx == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated
// repeat_cnt+1 times with an optional idle gap between repetitions.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [CNT_W-1:0] rep_left;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_left;
    logic [LEN_W-1:0] eff_len;
    logic             load;
    logic             restart;
    logic             advance;
    logic             last_bit;
    logic             more;

    assign eff_len = LEN_W'(clamp_len(32'(pat_len), PAT_W));
    assign more    = (rep_left != '0);
    assign load    = (state == ST_IDLE) && start && !abort;
    assign advance = !abort && (state == ST_SEND) && !last_bit;
    assign restart = !abort &&
                     (((state == ST_SEND) && last_bit && more && (gap_q == '0)) ||
                      ((state == ST_GAP) && (gap_left == '0)));

    seq_piso_shifter #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .restart  (restart),
        .advance  (advance),
        .data     (pattern),
        .len      (eff_len),
        .bit_out  (ser_out),
        .last_bit (last_bit)
    );

    // Outputs describe the cycle after each edge, so they are set alongside the state move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rep_left    <= '0;
            gap_q       <= '0;
            gap_left    <= '0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
            if (abort && state != ST_IDLE) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        busy <= 1'b0;
                        if (start && !abort) begin
                            rep_left    <= repeat_cnt;
                            gap_q       <= gap;
                            state       <= ST_SEND;
                            busy        <= 1'b1;
                            ser_valid   <= 1'b1;
                            frame_start <= 1'b1;
                        end
                    end
                    ST_SEND: begin
                        if (!last_bit) begin
                            ser_valid <= 1'b1;
                        end else if (more) begin
                            rep_left <= rep_left - CNT_W'(1);
                            if (gap_q == '0) begin
                                ser_valid   <= 1'b1;
                                frame_start <= 1'b1;
                            end else begin
                                gap_left <= gap_q - GAP_W'(1);
                                state    <= ST_GAP;
                            end
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (gap_left == '0) begin
                            state       <= ST_SEND;
                            ser_valid   <= 1'b1;
                            frame_start <= 1'b1;
                        end else begin
                            gap_left <= gap_left - GAP_W'(1);
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: per-cycle output traces compared
// against a trace built directly from the transmission rules.
module tb_seq_pattern_tx;

    localparam int PAT_W = 3;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] pat_len;
    logic [CNT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap;
    logic             abort;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    // Trace entries are {ser_valid, ser_out, frame_start, busy, done} for cycles 1, 2, ...
    logic [4:0] exp_q[$];
    logic [4:0] obs;

    seq_pattern_tx #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W),
        .GAP_W (GAP_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pattern     (pattern),
        .pat_len     (pat_len),
        .repeat_cnt  (repeat_cnt),
        .gap         (gap),
        .abort       (abort),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    assign obs = {ser_valid, ser_out, frame_start, busy, done};

    task automatic build_model(input logic [PAT_W-1:0] p, input int l_in, input int r, input int g);
        int len = (l_in == 0 || l_in > PAT_W) ? PAT_W : l_in;
        for (int k = 0; k <= r; k++) begin
            for (int b = len - 1; b >= 0; b--)
                exp_q.push_back({1'b1, p[b], (b == len - 1), 1'b1, 1'b0});
            if (k < r)
                for (int j = 0; j < g; j++) exp_q.push_back(5'b00010);
        end
        exp_q.push_back(5'b00011);
        exp_q.push_back(5'b00000);
    endtask

    task automatic scramble_inputs();
        pattern    = PAT_W'($urandom);
        pat_len    = LEN_W'($urandom);
        repeat_cnt = CNT_W'($urandom);
        gap        = GAP_W'($urandom);
    endtask

    task automatic launch(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                          input logic [CNT_W-1:0] r, input logic [GAP_W-1:0] g);
        @(negedge clk);
        pattern = p; pat_len = l; repeat_cnt = r; gap = g; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        scramble_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        pattern = '0; pat_len = '0; repeat_cnt = '0; gap = '0;
        #12;
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("[TB] FAIL reset got=%b want=%b", obs, 5'b00000);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_default();
        exp_q.delete();
        build_model(3'b101, 0, 0, 0);
        launch(3'b101, '0, '0, '0);
        foreach (exp_q[i]) begin
            @(negedge clk);
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("[TB] FAIL default cyc=%0d got=%b want=%b", i + 1, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        build_model(3'b101, 0, 2, 0);
        launch(3'b101, '0, 8'd2, '0);
        foreach (exp_q[i]) begin
            @(negedge clk);
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("[TB] FAIL b2b cyc=%0d got=%b want=%b", i + 1, obs, exp_q[i]);
            end
        end
        exp_q.delete();
        build_model(3'b001, 1, 255, 0);
        launch(3'b001, 2'd1, 8'hFF, '0);
        foreach (exp_q[i]) begin
            @(negedge clk);
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("[TB] FAIL maxrep cyc=%0d got=%b want=%b", i + 1, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_gap();
        exp_q.delete();
        build_model(3'b101, 0, 1, 2);
        launch(3'b101, '0, 8'd1, 4'd2);
        foreach (exp_q[i]) begin
            @(negedge clk);
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("[TB] FAIL gap cyc=%0d got=%b want=%b", i + 1, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_short();
        exp_q.delete();
        build_model(3'b110, 2, 0, 0);
        launch(3'b110, 2'd2, '0, '0);
        foreach (exp_q[i]) begin
            @(negedge clk);
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("[TB] FAIL short cyc=%0d got=%b want=%b", i + 1, obs, exp_q[i]);
            end
        end
        exp_q.delete();
        build_model(3'b011, 7, 0, 0);
        launch(3'b011, LEN_W'(7), '0, '0);
        foreach (exp_q[i]) begin
            @(negedge clk);
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("[TB] FAIL overlen cyc=%0d got=%b want=%b", i + 1, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_abort();
        int stray = 0;
        launch(3'b101, '0, '0, '0);
        @(negedge clk);
        total++;
        if (obs !== 5'b11110) begin
            bad++;
            $display("[TB] FAIL abort_c1 got=%b want=%b", obs, 5'b11110);
        end
        @(negedge clk);
        total++;
        if (obs !== 5'b10010) begin
            bad++;
            $display("[TB] FAIL abort_c2 got=%b want=%b", obs, 5'b10010);
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("[TB] FAIL abort_c3 got=%b want=%b", obs, 5'b00000);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (obs !== 5'b00000) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++;
            $display("[TB] FAIL abort_quiet active_cycles=%0d want=0", stray);
        end
    endtask

    task automatic test_ignored_start();
        int stray = 0;
        exp_q.delete();
        build_model(3'b100, 0, 1, 1);
        launch(3'b100, '0, 8'd1, 4'd1);
        foreach (exp_q[i]) begin
            @(negedge clk);
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("[TB] FAIL busy_start cyc=%0d got=%b want=%b", i + 1, obs, exp_q[i]);
            end
            if (i == 2) begin
                pattern = 3'b011; repeat_cnt = 8'd3; start = 1'b1;
            end
            if (i == 5) start = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (obs !== 5'b00000) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++;
            $display("[TB] FAIL busy_start_quiet active_cycles=%0d want=0", stray);
        end
    endtask

    task automatic test_start_held();
        int first_len;
        exp_q.delete();
        build_model(3'b110, 0, 0, 1);
        first_len = exp_q.size();
        build_model(3'b110, 0, 0, 1);
        @(negedge clk);
        pattern = 3'b110; pat_len = '0; repeat_cnt = '0; gap = 4'd1; start = 1'b1;
        @(posedge clk);
        foreach (exp_q[i]) begin
            @(negedge clk);
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("[TB] FAIL held_start cyc=%0d got=%b want=%b", i + 1, obs, exp_q[i]);
            end
            if (i == first_len) start = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        launch(3'b111, '0, 8'd1, 4'd3);
        repeat (4) @(negedge clk);
        total++;
        if (obs !== 5'b00010) begin
            bad++;
            $display("[TB] FAIL pre_rst_gap got=%b want=%b", obs, 5'b00010);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (obs !== 5'b00000) begin
            bad++;
            $display("[TB] FAIL async_rst got=%b want=%b", obs, 5'b00000);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        build_model(3'b101, 0, 1, 0);
        launch(3'b101, '0, 8'd1, '0);
        foreach (exp_q[i]) begin
            @(negedge clk);
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("[TB] FAIL post_rst cyc=%0d got=%b want=%b", i + 1, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [PAT_W-1:0] p;
        logic [LEN_W-1:0] l;
        logic [CNT_W-1:0] r;
        logic [GAP_W-1:0] g;
        for (int t = 0; t < 15; t++) begin
            p = PAT_W'($urandom);
            l = LEN_W'($urandom);
            r = CNT_W'($urandom_range(0, 4));
            g = GAP_W'($urandom_range(0, 5));
            exp_q.delete();
            build_model(p, int'(l), int'(r), int'(g));
            launch(p, l, r, g);
            foreach (exp_q[i]) begin
                @(negedge clk);
                total++;
                if (obs !== exp_q[i]) begin
                    bad++;
                    $display("[TB] FAIL random t=%0d cyc=%0d got=%b want=%b", t, i + 1, obs, exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_back_to_back();
        test_gap();
        test_short();
        test_abort();
        test_ignored_start();
        test_start_held();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
